// File: rtl/uart_rx_ctl.sv
// uart_rx_ctl: receive-side controller between a byte-level UART receiver and the core.
// Unloads bytes with a WAIT/UNLOAD/CAPTURE handshake, then assembles 4-byte big-endian
// frames terminated by DELIM into 32-bit words. Flags bad delimiters and inter-byte
// timeouts, and resynchronises by hunting for DELIM.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   enable       receive enable request from the core
//   rx_data      receiver byte, valid in the cycle after an uld_rx_data pulse
//   rx_empty     receiver holding register empty (0 = byte waiting)
//   uld_rx_data  one-cycle unload strobe to the receiver
//   rx_enable    receiver enable (registered copy of enable)
//   word_data    last complete word
//   word_valid   one-cycle pulse, word_data updated in the same cycle
//   frame_error  one-cycle pulse on a bad delimiter or a timeout
//   err_count    saturating count of frame_error pulses
//   synced       frame alignment established
module uart_rx_ctl #(
  parameter logic [7:0]  DELIM   = 8'h2C,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data,
  output logic        rx_enable,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_error,
  output logic [7:0]  err_count,
  output logic        synced
);

  typedef enum logic [1:0] {StWait, StUnload, StCapture} state_e;

  // Timeout fires when the idle counter would step onto TIMEOUT-1.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 32'd1);

  state_e      state_q;
  logic [2:0]  byte_cnt_q;
  logic [31:0] shift_q;
  logic [15:0] tmo_cnt_q;

  logic       capture;
  logic       tmo_run;
  logic       tmo_hit;
  logic [7:0] err_count_inc;

  always_comb begin
    capture       = (state_q == StCapture);
    // Counter only runs inside a partial frame.
    tmo_run       = synced && (byte_cnt_q != 3'd0);
    // A capture in the same cycle takes priority over the timeout.
    tmo_hit       = tmo_run && !capture && ((tmo_cnt_q + 16'd1) == TmoLast);
    err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StWait;
      byte_cnt_q  <= 3'd0;
      shift_q     <= 32'd0;
      tmo_cnt_q   <= 16'd0;
      uld_rx_data <= 1'b0;
      rx_enable   <= 1'b0;
      word_data   <= 32'd0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= 8'd0;
      synced      <= 1'b0;
    end else begin
      rx_enable   <= enable;
      uld_rx_data <= 1'b0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;

      // Handshake: the strobe is registered so it is high exactly in the UNLOAD cycle.
      case (state_q)
        StWait: begin
          if (rx_enable && !rx_empty) begin
            state_q     <= StUnload;
            uld_rx_data <= 1'b1;
          end
        end
        StUnload:  state_q <= StCapture;
        StCapture: state_q <= StWait;
        default:   state_q <= StWait;
      endcase

      // Parser and timeout.
      if (capture) begin
        tmo_cnt_q <= 16'd0;
        if (!synced) begin
          if (rx_data == DELIM) begin
            synced     <= 1'b1;
            byte_cnt_q <= 3'd0;
          end
        end else if (byte_cnt_q != 3'd4) begin
          // Positional framing: a DELIM value here is ordinary data.
          shift_q    <= {shift_q[23:0], rx_data};
          byte_cnt_q <= byte_cnt_q + 3'd1;
        end else if (rx_data == DELIM) begin
          word_data  <= shift_q;
          word_valid <= 1'b1;
          byte_cnt_q <= 3'd0;
        end else begin
          // Bad delimiter: drop alignment, the byte is not reused as a delimiter.
          frame_error <= 1'b1;
          err_count   <= err_count_inc;
          synced      <= 1'b0;
          byte_cnt_q  <= 3'd0;
        end
      end else if (tmo_hit) begin
        frame_error <= 1'b1;
        err_count   <= err_count_inc;
        synced      <= 1'b0;
        byte_cnt_q  <= 3'd0;
        shift_q     <= 32'd0;
        tmo_cnt_q   <= 16'd0;
      end else if (tmo_run) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end else begin
        tmo_cnt_q <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctl.sv
// Self-checking bench for uart_rx_ctl. A byte queue models the UART receiver; expected
// words are pushed to a scoreboard queue as frames are driven and popped on word_valid.
module tb_uart_rx_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic        rx_enable;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_error;
  logic [7:0]  err_count;
  logic        synced;

  always #5 clock = ~clock;

  uart_rx_ctl #(
    .DELIM  (8'h2C),
    .TIMEOUT(20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .uld_rx_data(uld_rx_data),
    .rx_enable  (rx_enable),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_error(frame_error),
    .err_count  (err_count),
    .synced     (synced)
  );

  logic [7:0]  rx_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_uld_cyc = 0;
  int last_fe_cyc = 0;
  int uld_pulses = 0;
  int fe_pulses = 0;
  int words_seen = 0;
  bit have_uld = 1'b0;
  bit prev_uld = 1'b0;
  int p0;
  int p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    rx_empty = 1'b0;
  endtask

  // Called at the falling edge: inspect the outputs of the current cycle.
  task automatic observe();
    logic [31:0] exp_w;
    if (uld_rx_data) begin
      check("uld_back_to_back", {31'd0, prev_uld}, 32'd0);
      if (have_uld) check("uld_spacing", {31'd0, (cyc - last_uld_cyc) >= 3}, 32'd1);
      have_uld     = 1'b1;
      last_uld_cyc = cyc;
      uld_pulses++;
    end
    prev_uld = uld_rx_data;
    if (word_valid) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        check("word_unexpected", exp_q.size(), 1);
      end else begin
        exp_w = exp_q.pop_front();
        check("word_data", word_data, exp_w);
        check("word_latency", cyc - last_uld_cyc, 2);
      end
    end
    if (frame_error) begin
      fe_pulses++;
      last_fe_cyc = cyc;
    end
  endtask

  task automatic step();
    logic do_pop;
    observe();
    do_pop = uld_rx_data;
    @(posedge clock);
    #1;
    if (do_pop && rx_q.size() > 0) rx_data = rx_q.pop_front();
    rx_empty = (rx_q.size() == 0);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_uld"}, {31'd0, uld_rx_data}, 32'd0);
    check({tag, "_rx_enable"}, {31'd0, rx_enable}, 32'd0);
    check({tag, "_word_data"}, word_data, 32'd0);
    check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    check({tag, "_synced"}, {31'd0, synced}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    rx_data  = 8'h00;
    rx_empty = 1'b1;
    @(negedge clock);
    run(3);
    reset = 1'b0;
    step();
    check_all_zero("reset");

    // rx_enable is a registered copy of enable.
    enable = 1'b1;
    check("rx_enable_pre", {31'd0, rx_enable}, 32'd0);
    step();
    check("rx_enable", {31'd0, rx_enable}, 32'd1);
    run(2);

    // Basic frame; strobe one cycle after rx_empty falls.
    push(8'h2C);
    step();
    check("uld_latency", {31'd0, uld_rx_data}, 32'd1);
    run(2);
    check("synced_after_delim", {31'd0, synced}, 32'd1);
    push(8'h12); push(8'h34); push(8'h56); push(8'h78); push(8'h2C);
    exp_q.push_back(32'h12345678);
    run(40);
    check("frame1_pending", exp_q.size(), 0);
    check("frame1_err", {24'd0, err_count}, 32'd0);
    check("frame1_synced", {31'd0, synced}, 32'd1);

    // Embedded delimiter value taken as data.
    push(8'h11); push(8'h2C); push(8'h33); push(8'h44); push(8'h2C);
    exp_q.push_back(32'h112C3344);
    run(30);
    check("frame2_pending", exp_q.size(), 0);
    check("frame2_word", word_data, 32'h112C3344);

    // Bad delimiter, then resync.
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); push(8'h55);
    run(30);
    check("baddelim_fe", fe_pulses, 1);
    check("baddelim_err", {24'd0, err_count}, 32'd1);
    check("baddelim_synced", {31'd0, synced}, 32'd0);
    push(8'h01); push(8'h02); push(8'h2C);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'h2C);
    exp_q.push_back(32'hA1A2A3A4);
    run(40);
    check("resync_pending", exp_q.size(), 0);
    check("resync_synced", {31'd0, synced}, 32'd1);

    // Timeout: frame_error 20 cycles after the capture of the second byte.
    push(8'h01); push(8'h02);
    run(40);
    check("timeout_fe", fe_pulses, 2);
    check("timeout_latency", last_fe_cyc - last_uld_cyc, 21);
    check("timeout_err", {24'd0, err_count}, 32'd2);
    check("timeout_synced", {31'd0, synced}, 32'd0);
    push(8'h2C); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF); push(8'h2C);
    exp_q.push_back(32'hDEADBEEF);
    run(40);
    check("after_timeout_pending", exp_q.size(), 0);

    // Continuous stream of bad frames: strobe rate, enable gating, saturation.
    push(8'h00); push(8'h00); push(8'h00); push(8'h00); push(8'h55);
    for (int i = 0; i < 300; i++) begin
      push(8'h2C); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); push(8'h55);
    end
    run(30);
    p0 = uld_pulses;
    run(300);
    check("uld_rate", uld_pulses - p0, 100);
    enable = 1'b0;
    run(3);
    p1 = uld_pulses;
    run(30);
    check("uld_stop", uld_pulses - p1, 0);
    enable = 1'b1;
    run(5400);
    check("sat_drained", rx_q.size(), 0);
    check("sat_err", {24'd0, err_count}, 32'd255);
    check("sat_synced", {31'd0, synced}, 32'd0);

    // Reset mid-frame.
    push(8'h2C); push(8'h01); push(8'h02);
    run(12);
    check("premid_synced", {31'd0, synced}, 32'd1);
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    run(3);
    push(8'h2C); push(8'hCA); push(8'hFE); push(8'hF0); push(8'h0D); push(8'h2C);
    exp_q.push_back(32'hCAFEF00D);
    run(40);
    check("postreset_pending", exp_q.size(), 0);
    check("postreset_word", word_data, 32'hCAFEF00D);
    check("postreset_err", {24'd0, err_count}, 32'd0);
    check("words_total", words_seen, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
